// File: rtl/tl_rx_fc_update_gen.sv
// Gathers posted/non-posted/completion FC update requests plus a periodic refresh,
// arbitrates them round-robin and issues one UpdateFC snapshot at a time over valid/ready.
module tl_rx_fc_update_gen #(
    parameter int unsigned HDR_FIELD_SIZE      = 12,
    parameter int unsigned DATA_FIELD_SIZE     = 16,
    parameter int unsigned UPDATE_TIMER_CYCLES = 30000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fc_init_done,
    input  logic                       p_hdr_update,
    input  logic                       p_data_update,
    input  logic                       np_hdr_update,
    input  logic                       np_data_update,
    input  logic                       cpl_hdr_update,
    input  logic                       cpl_data_update,
    input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_p,
    input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_np,
    input  logic [HDR_FIELD_SIZE-1:0]  creds_alloc_hdr_cpl,
    input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_p,
    input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_np,
    input  logic [DATA_FIELD_SIZE-1:0] creds_alloc_data_cpl,
    input  logic [1:0]                 hdr_scale_in,
    input  logic [1:0]                 data_scale_in,
    output logic                       updatefc_valid,
    input  logic                       updatefc_ready,
    output logic [1:0]                 updatefc_typ,
    output logic [HDR_FIELD_SIZE-1:0]  updatefc_hdr_fc,
    output logic [DATA_FIELD_SIZE-1:0] updatefc_data_fc,
    output logic [1:0]                 updatefc_hdr_scale,
    output logic [1:0]                 updatefc_data_scale
);

    localparam int unsigned   TW         = $clog2(UPDATE_TIMER_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(UPDATE_TIMER_CYCLES - 1);
    localparam logic [1:0]    TYP_P      = 2'd0;
    localparam logic [1:0]    TYP_NP     = 2'd1;
    localparam logic [1:0]    TYP_CPL    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 pend_q, pend_d;
    logic [2:0]                 upd_q, upd_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [1:0]                 rr_q, rr_d;
    logic                       valid_q, valid_d;
    logic [1:0]                 typ_q, typ_d;
    logic [HDR_FIELD_SIZE-1:0]  hdr_q, hdr_d;
    logic [DATA_FIELD_SIZE-1:0] data_q, data_d;
    logic [1:0]                 hsc_q, hsc_d;
    logic [1:0]                 dsc_q, dsc_d;

    logic                       hs;
    logic                       expire;
    logic [2:0]                 clr;
    logic [1:0]                 win;
    logic [HDR_FIELD_SIZE-1:0]  win_hdr;
    logic [DATA_FIELD_SIZE-1:0] win_data;

    // First pending type strictly after the last winner, wrapping P -> NP -> CPL -> P.
    always_comb begin
        win = TYP_P;
        case (rr_q)
            TYP_P:   win = pend_q[1] ? TYP_NP  : (pend_q[2] ? TYP_CPL : TYP_P);
            TYP_NP:  win = pend_q[2] ? TYP_CPL : (pend_q[0] ? TYP_P   : TYP_NP);
            default: win = pend_q[0] ? TYP_P   : (pend_q[1] ? TYP_NP  : TYP_CPL);
        endcase
    end

    always_comb begin
        win_hdr  = creds_alloc_hdr_p;
        win_data = creds_alloc_data_p;
        case (win)
            TYP_NP: begin
                win_hdr  = creds_alloc_hdr_np;
                win_data = creds_alloc_data_np;
            end
            TYP_CPL: begin
                win_hdr  = creds_alloc_hdr_cpl;
                win_data = creds_alloc_data_cpl;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        valid_d = valid_q;
        typ_d   = typ_q;
        hdr_d   = hdr_q;
        data_d  = data_q;
        hsc_d   = hsc_q;
        dsc_d   = dsc_q;

        hs      = (state_q == ST_SEND) && valid_q && updatefc_ready;
        expire  = fc_init_done && (timer_q == TIMER_LAST);
        clr     = hs ? (3'b001 << typ_q) : 3'b000;

        // Pulses go through one register stage; a pulse coinciding with its own
        // handshake therefore lands after the clear and re-arms the type.
        if (!fc_init_done) begin
            timer_d = '0;
            upd_d   = '0;
            pend_d  = '0;
        end else begin
            timer_d = expire ? '0 : timer_q + 1'b1;
            upd_d   = {cpl_hdr_update | cpl_data_update,
                       np_hdr_update  | np_data_update,
                       p_hdr_update   | p_data_update};
            pend_d  = (pend_q & ~clr) | upd_q | {3{expire}};
        end

        if (!fc_init_done) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            typ_d   = '0;
            hdr_d   = '0;
            data_d  = '0;
            hsc_d   = '0;
            dsc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARB;
                ST_ARB: begin
                    if (|pend_q) begin
                        state_d = ST_SEND;
                        valid_d = 1'b1;
                        typ_d   = win;
                        hdr_d   = win_hdr;
                        data_d  = win_data;
                        hsc_d   = hdr_scale_in;
                        dsc_d   = data_scale_in;
                        rr_d    = win;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        state_d = ST_ARB;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            upd_q   <= '0;
            timer_q <= '0;
            rr_q    <= TYP_CPL;
            valid_q <= 1'b0;
            typ_q   <= '0;
            hdr_q   <= '0;
            data_q  <= '0;
            hsc_q   <= '0;
            dsc_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            upd_q   <= upd_d;
            timer_q <= timer_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            typ_q   <= typ_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            hsc_q   <= hsc_d;
            dsc_q   <= dsc_d;
        end
    end

    assign updatefc_valid      = valid_q;
    assign updatefc_typ        = typ_q;
    assign updatefc_hdr_fc     = hdr_q;
    assign updatefc_data_fc    = data_q;
    assign updatefc_hdr_scale  = hsc_q;
    assign updatefc_data_scale = dsc_q;

endmodule
